// File: rtl/cvita_framer_pkg.sv
// Shared definitions for the multi-channel CVITA framer: header field layout,
// output FSM states and settings-register offsets.
package cvita_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  localparam int SR_SPP_OFS = 0;
  localparam int SR_DST_OFS = 1;

  localparam logic [15:0] SPP_RESET = 16'd64;

  localparam int HDR_EOB_BIT = 60;
  localparam int HDR_SEQ_LSB = 48;
  localparam int HDR_LEN_LSB = 32;
  localparam int HDR_SID_LSB = 0;

  // Packet length field counts bytes including the header word itself.
  function automatic logic [63:0] make_header(
    input logic        eob,
    input logic [11:0] seq,
    input logic [15:0] words,
    input logic [15:0] src_sid,
    input logic [7:0]  chan,
    input logic [15:0] dst
  );
    logic [63:0] hdr;
    hdr = '0;
    hdr[HDR_EOB_BIT]         = eob;
    hdr[HDR_SEQ_LSB +: 12]   = seq;
    hdr[HDR_LEN_LSB +: 16]   = (words + 16'd1) << 3;
    hdr[HDR_SID_LSB +: 32]   = {src_sid[15:8], src_sid[7:0] + chan, dst};
    return hdr;
  endfunction

endpackage

// File: rtl/cvita_multi_framer_if.sv
// Stream bundle of the framer: per-channel payload inputs and the framed output.
interface cvita_multi_framer_if #(
  parameter int NUM_CHANNELS = 2
);
  logic [64*NUM_CHANNELS-1:0] s_axis_tdata;
  logic [NUM_CHANNELS-1:0]    s_axis_tlast;
  logic [NUM_CHANNELS-1:0]    s_axis_tvalid;
  logic [NUM_CHANNELS-1:0]    s_axis_tready;
  logic [63:0]                m_axis_tdata;
  logic                       m_axis_tlast;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/cvita_framer_chan.sv
// One framer channel: payload FIFO, 4-deep {eob, length} FIFO and the word
// counter that cuts the input stream into packets.
module cvita_framer_chan
  import cvita_framer_pkg::*;
#(
  parameter int FIFO_SIZE = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] spp_eff,
  input  logic [63:0] in_tdata,
  input  logic        in_tlast,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic        pkt_valid,
  output logic [15:0] pkt_words,
  output logic        pkt_eob,
  input  logic        pkt_pop,
  output logic [63:0] data_head,
  input  logic        data_pop
);
  localparam int DEPTH = 1 << FIFO_SIZE;

  logic [63:0]        data_mem [DEPTH];
  logic [FIFO_SIZE:0] data_wr, data_rd;
  logic [16:0]        len_mem [4];
  logic [2:0]         len_wr, len_rd;
  logic [15:0]        word_cnt;
  logic               in_en;
  logic               data_full, len_full, accept, close;

  assign data_full = (data_wr[FIFO_SIZE] != data_rd[FIFO_SIZE]) &&
                     (data_wr[FIFO_SIZE-1:0] == data_rd[FIFO_SIZE-1:0]);
  assign len_full  = (len_wr[2] != len_rd[2]) && (len_wr[1:0] == len_rd[1:0]);
  assign in_tready = in_en & ~data_full & ~len_full;
  assign accept    = in_tvalid & in_tready;
  assign close     = in_tlast | (({1'b0, word_cnt} + 17'd1) >= spp_eff);

  // NOTE: storage arrays carry no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (accept) data_mem[data_wr[FIFO_SIZE-1:0]] <= in_tdata;
    if (accept && close) len_mem[len_wr[1:0]] <= {in_tlast, word_cnt + 16'd1};
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_en    <= 1'b0;
      data_wr  <= '0;
      data_rd  <= '0;
      len_wr   <= '0;
      len_rd   <= '0;
      word_cnt <= '0;
    end else begin
      in_en <= 1'b1;
      if (accept) begin
        data_wr  <= data_wr + 1'b1;
        word_cnt <= close ? 16'd0 : word_cnt + 16'd1;
        if (close) len_wr <= len_wr + 1'b1;
      end
      if (data_pop) data_rd <= data_rd + 1'b1;
      if (pkt_pop)  len_rd  <= len_rd + 1'b1;
    end
  end

  assign pkt_valid            = (len_wr != len_rd);
  assign {pkt_eob, pkt_words} = len_mem[len_rd[1:0]];
  assign data_head            = data_mem[data_rd[FIFO_SIZE-1:0]];

endmodule

// File: rtl/cvita_multi_framer.sv
// Frames NUM_CHANNELS payload streams into CVITA packets on a single output,
// serving closed packets round-robin without interleaving channels.
module cvita_multi_framer
  import cvita_framer_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int SR_BASE      = 128,
  parameter int FIFO_SIZE    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_tx_seqnum,
  input  logic [15:0] src_sid,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  cvita_multi_framer_if.slave bus
);
  localparam int          CW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [16:0] SPP_MAX = 17'(1 << FIFO_SIZE);

  state_t                  state;
  logic [15:0]             spp;
  logic [16:0]             spp_eff;
  logic [15:0]             next_dst [NUM_CHANNELS];
  logic [11:0]             seqnum [NUM_CHANNELS];
  logic [CW-1:0]           sel, rr_ptr, pick_idx;
  logic                    pick_found;
  int                      cand;
  logic [15:0]             words_left;
  logic [63:0]             hdr;
  logic                    hdr_done, pay_hs;
  logic [NUM_CHANNELS-1:0] pkt_valid, pkt_eob, pkt_pop, data_pop;
  logic [15:0]             pkt_words [NUM_CHANNELS];
  logic [63:0]             data_head [NUM_CHANNELS];
  logic                    unused_set_hi;

  assign unused_set_hi = ^set_data[31:16];
  assign spp_eff = (spp == 16'd0 || {1'b0, spp} > SPP_MAX) ? SPP_MAX : {1'b0, spp};
  assign hdr_done = (state == ST_HEADER) && bus.m_axis_tready;
  assign pay_hs   = (state == ST_PAYLOAD) && bus.m_axis_tready;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign data_pop[c] = (sel == CW'(c)) && (hdr_done || (pay_hs && !bus.m_axis_tlast));
    assign pkt_pop[c]  = (sel == CW'(c)) && pay_hs && bus.m_axis_tlast;

    cvita_framer_chan #(.FIFO_SIZE(FIFO_SIZE)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .spp_eff   (spp_eff),
      .in_tdata  (bus.s_axis_tdata[64*c +: 64]),
      .in_tlast  (bus.s_axis_tlast[c]),
      .in_tvalid (bus.s_axis_tvalid[c]),
      .in_tready (bus.s_axis_tready[c]),
      .pkt_valid (pkt_valid[c]),
      .pkt_words (pkt_words[c]),
      .pkt_eob   (pkt_eob[c]),
      .pkt_pop   (pkt_pop[c]),
      .data_head (data_head[c]),
      .data_pop  (data_pop[c])
    );
  end

  // Scan downwards so the channel closest after rr_ptr is the one kept.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
      if (pkt_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = CW'(cand);
      end
    end
    hdr = make_header(pkt_eob[pick_idx], seqnum[pick_idx], pkt_words[pick_idx],
                      src_sid, 8'(pick_idx), next_dst[pick_idx]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spp <= SPP_RESET;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        next_dst[c] <= '0;
        seqnum[c]   <= '0;
      end
    end else begin
      if (set_stb && set_addr == 8'(SR_BASE + SR_SPP_OFS)) spp <= set_data[15:0];
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (set_stb && set_addr == 8'(SR_BASE + SR_DST_OFS + c)) next_dst[c] <= set_data[15:0];
        // Clear takes priority over a coincident header handshake.
        if (clear_tx_seqnum)                   seqnum[c] <= '0;
        else if (hdr_done && sel == CW'(c))    seqnum[c] <= seqnum[c] + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      sel               <= '0;
      rr_ptr            <= '0;
      words_left        <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tdata  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_found) begin
            sel               <= pick_idx;
            rr_ptr            <= (pick_idx == CW'(NUM_CHANNELS - 1)) ? '0 : pick_idx + 1'b1;
            bus.m_axis_tdata  <= hdr;
            bus.m_axis_tvalid <= 1'b1;
            bus.m_axis_tlast  <= 1'b0;
            state             <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (bus.m_axis_tready) begin
            bus.m_axis_tdata <= data_head[sel];
            bus.m_axis_tlast <= (pkt_words[sel] == 16'd1);
            words_left       <= pkt_words[sel] - 16'd1;
            state            <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (bus.m_axis_tready) begin
            if (bus.m_axis_tlast) begin
              bus.m_axis_tvalid <= 1'b0;
              bus.m_axis_tlast  <= 1'b0;
              state             <= ST_IDLE;
            end else begin
              bus.m_axis_tdata <= data_head[sel];
              bus.m_axis_tlast <= (words_left == 16'd1);
              words_left       <= words_left - 16'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cvita_multi_framer.sv
// Directed bench for cvita_multi_framer: packetisation, round-robin, stalls,
// sequence-number wrap/clear and mid-packet reset.
module tb_cvita_multi_framer;
  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_tx_seqnum = 1'b0;
  logic [15:0] src_sid = 16'hAB12;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;

  cvita_multi_framer_if #(.NUM_CHANNELS(NCH)) bus ();

  cvita_multi_framer #(.NUM_CHANNELS(NCH), .SR_BASE(128), .FIFO_SIZE(9)) dut (
    .clk             (clk),
    .reset           (reset),
    .clear_tx_seqnum (clear_tx_seqnum),
    .src_sid         (src_sid),
    .set_stb         (set_stb),
    .set_addr        (set_addr),
    .set_data        (set_data),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       beats[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_bad = 0;
  int          stall_cnt = 0;
  int          rd = 0;
  logic [11:0] exp_seq [NCH];
  logic [15:0] exp_dst [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: records handshakes and checks stability across stalls.
  initial begin : monitor
    logic        held_pending;
    logic [63:0] held_data;
    logic        held_last;
    held_pending = 1'b0;
    held_data    = '0;
    held_last    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_pending = 1'b0;
      end else begin
        if (held_pending) begin
          stall_cnt++;
          if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== held_data ||
              bus.m_axis_tlast !== held_last) stall_bad++;
        end
        held_pending = bus.m_axis_tvalid && !bus.m_axis_tready;
        held_data    = bus.m_axis_tdata;
        held_last    = bus.m_axis_tlast;
        if (bus.m_axis_tvalid && bus.m_axis_tready)
          beats.push_back({bus.m_axis_tdata, bus.m_axis_tlast});
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic send_word(input int ch, input logic [63:0] d, input logic l);
    int t;
    bus.s_axis_tdata[ch*64 +: 64] = d;
    bus.s_axis_tvalid[ch] = 1'b1;
    bus.s_axis_tlast[ch]  = l;
    t = 0;
    while (bus.s_axis_tready[ch] !== 1'b1 && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) check("in_ready_timeout", 64'(bus.s_axis_tready[ch]), 64'd1);
    tick();
    bus.s_axis_tvalid[ch] = 1'b0;
    bus.s_axis_tlast[ch]  = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input int n, input logic [63:0] base, input logic last);
    for (int i = 0; i < n; i++) send_word(ch, base + 64'(i), last && (i == n - 1));
  endtask

  task automatic wait_beats(input int total, input int budget);
    int t;
    t = 0;
    while (beats.size() < total && t < budget) begin
      tick();
      t++;
    end
    if (beats.size() < total) check("beat_timeout", 64'(beats.size()), 64'(total));
  endtask

  task automatic wait_tvalid(input string tag);
    int t;
    t = 0;
    while (bus.m_axis_tvalid !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check(tag, 64'(bus.m_axis_tvalid), 64'd1);
  endtask

  // Checks one packet starting at beat idx and advances idx past it.
  task automatic check_pkt(input string tag, inout int idx, input int ch, input int n,
                           input logic eob, input logic [63:0] base);
    logic [63:0] exp_hdr;
    int          cnt, bad, j;
    logic        done;
    exp_hdr = {2'b00, 1'b0, eob, exp_seq[ch], 16'((n + 1) * 8),
               src_sid[15:8], 8'(src_sid[7:0] + 8'(ch)), exp_dst[ch]};
    check({tag, "_hdr"}, beats[idx].data, exp_hdr);
    check({tag, "_hdr_last"}, 64'(beats[idx].last), 64'd0);
    cnt  = 0;
    bad  = 0;
    j    = idx + 1;
    done = 1'b0;
    while (!done && j < beats.size()) begin
      if (beats[j].data !== base + 64'(cnt)) bad++;
      cnt++;
      done = beats[j].last;
      j++;
    end
    check({tag, "_len"}, 64'(cnt), 64'(n));
    check({tag, "_data"}, 64'(bad), 64'd0);
    idx = j;
    exp_seq[ch] = exp_seq[ch] + 12'd1;
  endtask

  initial begin : main
    int k, bad, nlast;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      exp_seq[c] = '0;
      exp_dst[c] = '0;
    end

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
    check("rst_tdata", bus.m_axis_tdata, 64'd0);
    check("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_s_tready", 64'(bus.s_axis_tready), 64'h3);

    set_reg(8'd128, 32'd4);
    set_reg(8'd129, 32'h0000_0D00);
    set_reg(8'd130, 32'h0000_0D11);
    set_reg(8'd131, 32'h0000_FFFF);
    set_reg(8'd127, 32'h0000_EEEE);
    exp_dst[0] = 16'h0D00;
    exp_dst[1] = 16'h0D11;

    // SPP=4, 10 words -> 4,4,2
    bus.m_axis_tready = 1'b1;
    send_pkt(0, 10, 64'd100, 1'b1);
    wait_beats(rd + 13, 300);
    check_pkt("spp4_a", rd, 0, 4, 1'b0, 64'd100);
    check_pkt("spp4_b", rd, 0, 4, 1'b0, 64'd104);
    check_pkt("spp4_c", rd, 0, 2, 1'b1, 64'd108);

    // Header latency from an idle output
    send_word(1, 64'h55, 1'b1);
    k = 0;
    while (bus.m_axis_tvalid !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("hdr_latency_le3", 64'(k <= 3), 64'd1);
    wait_beats(rd + 2, 50);
    check_pkt("lat", rd, 1, 1, 1'b1, 64'h55);

    // Both channels pending: round-robin alternation
    bus.m_axis_tready = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(0, 4, 64'(200 + 4 * p), 1'b1);
    for (int p = 0; p < 3; p++) send_pkt(1, 4, 64'(300 + 4 * p), 1'b1);
    bus.m_axis_tready = 1'b1;
    wait_beats(rd + 30, 300);
    for (int p = 0; p < 3; p++) begin
      check_pkt($sformatf("rr%0d_ch0", p), rd, 0, 4, 1'b1, 64'(200 + 4 * p));
      check_pkt($sformatf("rr%0d_ch1", p), rd, 1, 4, 1'b1, 64'(300 + 4 * p));
    end

    // SPP=0 acts as 512; 64-word packet under random backpressure
    set_reg(8'd128, 32'd0);
    bus.m_axis_tready = 1'b0;
    send_pkt(0, 64, 64'd1000, 1'b1);
    k = 0;
    while (beats.size() < rd + 65 && k < 2000) begin
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    bus.m_axis_tready = 1'b1;
    wait_beats(rd + 65, 20);
    check_pkt("stall64", rd, 0, 64, 1'b1, 64'd1000);
    check("stall_stable", 64'(stall_bad), 64'd0);
    check("stalls_seen", 64'(stall_cnt > 0), 64'd1);

    // SPP lowered mid-packet closes on the next accepted word
    set_reg(8'd128, 32'd64);
    send_pkt(1, 5, 64'd400, 1'b0);
    set_reg(8'd128, 32'd2);
    send_word(1, 64'd405, 1'b0);
    send_word(1, 64'd406, 1'b1);
    wait_beats(rd + 9, 200);
    check_pkt("spp_drop", rd, 1, 6, 1'b0, 64'd400);
    check_pkt("spp_drop_tail", rd, 1, 1, 1'b1, 64'd406);

    // Sequence number wrap over 4097 single-word packets
    clear_tx_seqnum = 1'b1;
    tick();
    clear_tx_seqnum = 1'b0;
    exp_seq[0] = '0;
    exp_seq[1] = '0;
    for (int i = 0; i < 4097; i++) send_word(0, 64'(i), 1'b1);
    wait_beats(rd + 2 * 4097, 2000);
    bad = 0;
    for (int i = 0; i < 4097; i++) begin
      if (beats[rd + 2 * i].data[59:48] !== 12'(i % 4096)) bad++;
      if (beats[rd + 2 * i + 1].data !== 64'(i) || beats[rd + 2 * i + 1].last !== 1'b1) bad++;
    end
    check("wrap_all", 64'(bad), 64'd0);
    check("wrap_seq4095", 64'(beats[rd + 2 * 4095].data[59:48]), 64'd4095);
    check("wrap_seq0", 64'(beats[rd + 2 * 4096].data[59:48]), 64'd0);
    rd = rd + 2 * 4097;
    exp_seq[0] = 12'd1;

    // Clear coincident with a header handshake
    bus.m_axis_tready = 1'b0;
    send_word(0, 64'h77, 1'b1);
    wait_tvalid("clr_hdr_timeout");
    bus.m_axis_tready = 1'b1;
    clear_tx_seqnum   = 1'b1;
    tick();
    clear_tx_seqnum   = 1'b0;
    wait_beats(rd + 2, 50);
    check_pkt("clr_coinc", rd, 0, 1, 1'b1, 64'h77);
    exp_seq[0] = '0;
    exp_seq[1] = '0;
    send_word(0, 64'h78, 1'b1);
    wait_beats(rd + 2, 50);
    check_pkt("clr_after", rd, 0, 1, 1'b1, 64'h78);

    // Reset during PAYLOAD
    set_reg(8'd128, 32'd8);
    set_reg(8'd129, 32'h0000_1234);
    bus.m_axis_tready = 1'b0;
    send_pkt(0, 8, 64'd500, 1'b1);
    wait_tvalid("rst_hdr_timeout");
    bus.m_axis_tready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("midrst_tlast", 64'(bus.m_axis_tlast), 64'd0);
    check("midrst_tdata", bus.m_axis_tdata, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    nlast = 0;
    for (int i = rd; i < beats.size(); i++) if (beats[i].last) nlast++;
    check("midrst_no_tlast", 64'(nlast), 64'd0);
    rd = beats.size();
    exp_seq[0] = '0;
    exp_seq[1] = '0;
    exp_dst[0] = '0;
    exp_dst[1] = '0;
    send_pkt(0, 64, 64'd2000, 1'b0);
    send_pkt(0, 1, 64'd2064, 1'b1);
    wait_beats(rd + 67, 500);
    check_pkt("post_rst_spp64", rd, 0, 64, 1'b0, 64'd2000);
    check_pkt("post_rst_tail", rd, 0, 1, 1'b1, 64'd2064);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cvita_multi_framer.md
CVITA_MULTI_FRAMER -- requirements
Module: cvita_multi_framer

Interface
REQ-001 Parameter NUM_CHANNELS, default 2, number of independent input channels (1..8).
REQ-002 Parameter SR_BASE, default 128, settings-bus base address.
REQ-003 Parameter FIFO_SIZE, default 9, log2 payload words buffered per channel.
REQ-004 Ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-005 Ports: clear_tx_seqnum  in  1  zero all sequence numbers; src_sid  in  16  base source SID.
REQ-006 Ports: set_stb  in  1; set_addr  in  8; set_data  in  32  settings bus write.
REQ-007 Ports: s_axis_tdata  in  64*NUM_CHANNELS; s_axis_tlast/tvalid  in  NUM_CHANNELS; s_axis_tready  out  NUM_CHANNELS  per-channel payload input, channel c in bits [64c+63:64c].
REQ-008 Ports: m_axis_tdata  out  64; m_axis_tlast/tvalid  out  1; m_axis_tready  in  1  framed CVITA output.

Function
REQ-009 Register SPP (16 b, SR_BASE+0) SHALL set max payload words/packet; 0 or >2^FIFO_SIZE SHALL act as 2^FIFO_SIZE.
REQ-010 Register NEXT_DST[c] (16 b, SR_BASE+1+c) SHALL give channel c destination SID; writes to other addresses ignored.
REQ-011 Channel c SHALL accept input iff its data FIFO and length FIFO both have space; s_axis_tready[c] reflects this combinationally from registered FIFO state.
REQ-012 Per-channel word counter SHALL close a packet on the accepted word where tlast=1 or count+1 >= SPP_eff; closure pushes {length, eob} into length FIFO (depth 4), counter returns to 0.
REQ-013 eob SHALL be 1 only when closure was caused by input tlast; SPP lowered mid-packet closes on the next accepted word.
REQ-014 Output FSM states IDLE, HEADER, PAYLOAD; IDLE→HEADER when any channel has a closed packet, selecting round-robin starting at last-served+1.
REQ-015 HEADER SHALL drive header word: [63:62]=00, [61]=0, [60]=eob, [59:48]=seqnum[c], [47:32]=8*(payload words+1), [31:0]={src_sid[15:8], src_sid[7:0]+c mod 256, NEXT_DST[c]}.
REQ-016 HEADER→PAYLOAD on header handshake; seqnum[c] SHALL increment then, wrapping 4095→0.
REQ-017 PAYLOAD SHALL stream channel c FIFO words, m_axis_tlast on the final word; handshake of final word → IDLE and pops length FIFO.
REQ-018 m_axis_tvalid/tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-019 With output idle and no other pending channel, header tvalid SHALL assert within 3 cycles of the closing input word's handshake.
REQ-020 clear_tx_seqnum SHALL zero all seqnums next cycle; if coincident with a header handshake, clear wins (next header of that channel carries 0); in-flight packet unaffected otherwise.
REQ-021 Channels SHALL never interleave within one output packet; sustained throughput after header is one word/cycle.

Reset
REQ-022 On reset: FSM IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 for one cycle then 1.
REQ-023 On reset: FIFOs flushed, counters 0, seqnums 0, SPP=64, NEXT_DST=0, round-robin pointer 0; reset mid-packet discards partial output without emitting tlast.

Structure
REQ-024 Package cvita_framer_pkg SHALL hold header field positions, FSM state enum, SR offset constants.
REQ-025 Sub-module cvita_framer_chan SHALL contain one channel's data FIFO, length FIFO and word counter; instantiated NUM_CHANNELS times via generate.

Verification
REQ-026 SPP=4, ch0 sends 10 words, tlast on 10th -> packets of 4,4,2 payload; lengths 40,40,24; eob 0,0,1; seqnums 0,1,2.
REQ-027 NUM_CHANNELS=2, both channels continuously supply 4-word packets -> output alternates ch0,ch1; SID low byte src_sid[7:0]+0 / +1; NEXT_DST per channel.
REQ-028 Random m_axis_tready (50%) during 64-word packet -> data matches input order, tdata stable during stalls, single tlast.
REQ-029 Send 4097 1-word packets on ch0 -> seqnum wraps 4095→0; assert clear_tx_seqnum on a header handshake -> next header seqnum 0.
REQ-030 Reset asserted during PAYLOAD -> next cycle tvalid=0; post-reset packet has seqnum 0, SPP 64, NEXT_DST 0.
